// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the two-requester SPI flash read arbiter.
package spi_flash_pkg;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         BIT_COUNT = 64;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_e;
   typedef enum logic {GNT_IF, GNT_DR} grant_e;

   // Received stream is MSB-first per byte with the first byte in the top bits;
   // requesters want that first byte in the low lane.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI bit sequencer: 32 bits out (cmd+addr), then 32 bits in, one
// frame per start pulse, with chip select held low for the whole frame.
module spi_bit_engine
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] tx_word,
   output logic [31:0] rx_word,
   output logic        done,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   localparam int            DW       = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [5:0]    BIT_LAST = 6'(BIT_COUNT - 1);

   logic          active_q, active_d;
   logic          sck_q, sck_d;
   logic          mosi_q, mosi_d;
   logic [DW-1:0] div_q, div_d;
   logic [5:0]    bit_q, bit_d;
   logic [31:0]   tx_q, tx_d;
   logic [31:0]   rx_q, rx_d;
   logic          phase_end;

   assign phase_end = active_q && (div_q == DIV_LAST);
   assign done      = phase_end && sck_q && (bit_q == BIT_LAST);

   always_comb begin
      active_d = active_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      if (start && !active_q) begin
         active_d = 1'b1;
         sck_d    = 1'b0;
         mosi_d   = tx_word[31];
         tx_d     = {tx_word[30:0], 1'b0};
         div_d    = '0;
         bit_d    = '0;
      end else if (active_q) begin
         div_d = phase_end ? '0 : div_q + DW'(1);
         if (phase_end && !sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[30:0], spi_miso};
         end else if (phase_end && sck_q) begin
            // MOSI only moves as SCK falls; once the 32 tx bits are gone it shifts in zeros
            sck_d = 1'b0;
            if (done) begin
               active_d = 1'b0;
               mosi_d   = 1'b0;
            end else begin
               bit_d  = bit_q + 6'd1;
               mosi_d = tx_q[31];
               tx_d   = {tx_q[30:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
      end else begin
         active_q <= active_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
      end
   end

   assign rx_word  = rx_q;
   assign spi_cs_n = ~active_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;
endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter between instruction fetch and data read sharing one
// SPI flash; each grant runs a single READ (0x03) returning a 32-bit LE word.
module spi_flash_arbiter
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 1,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [23:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        dr_req,
   input  logic [23:0] dr_addr,
   output logic        dr_ack,
   output logic [31:0] dr_rdata,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        busy
);
   localparam int            GW       = $clog2(CS_GAP) + 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   state_e        state_q, state_d;
   grant_e        gnt_q, gnt_d;
   grant_e        last_q, last_d;
   grant_e        pick;
   logic [GW-1:0] gap_q, gap_d;
   logic          if_ack_q, if_ack_d;
   logic          dr_ack_q, dr_ack_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   dr_rdata_q, dr_rdata_d;
   logic          start;
   logic [31:0]   tx_word;
   logic [31:0]   rx_word;
   logic          eng_done;

   // Under contention the requester that did not win last time goes next
   always_comb begin
      if (if_req && dr_req) begin
         pick = (last_q == GNT_DR) ? GNT_IF : GNT_DR;
      end else if (dr_req) begin
         pick = GNT_DR;
      end else begin
         pick = GNT_IF;
      end
   end

   assign start   = (state_q == IDLE) && (if_req || dr_req);
   assign tx_word = {CMD_READ, (pick == GNT_IF) ? if_addr : dr_addr};

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      gap_d      = gap_q;
      if_ack_d   = 1'b0;
      dr_ack_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      dr_rdata_d = dr_rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               gnt_d   = pick;
               last_d  = pick;
            end
         end
         SHIFT: begin
            if (eng_done) begin
               state_d = DONE;
               if (gnt_q == GNT_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bswap32(rx_word);
               end else begin
                  dr_ack_d   = 1'b1;
                  dr_rdata_d = bswap32(rx_word);
               end
            end
         end
         DONE: begin
            state_d = GAP;
            gap_d   = '0;
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_IF;
         last_q     <= GNT_DR;
         gap_q      <= '0;
         if_ack_q   <= 1'b0;
         dr_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dr_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         gap_q      <= gap_d;
         if_ack_q   <= if_ack_d;
         dr_ack_q   <= dr_ack_d;
         if_rdata_q <= if_rdata_d;
         dr_rdata_q <= dr_rdata_d;
      end
   end

   spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .tx_word  (tx_word),
      .rx_word  (rx_word),
      .done     (eng_done),
      .spi_cs_n (spi_cs_n),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   assign if_ack   = if_ack_q;
   assign dr_ack   = dr_ack_q;
   assign if_rdata = if_rdata_q;
   assign dr_rdata = dr_rdata_q;
   assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Two arbiters (CLK_DIV=1 and CLK_DIV=3) each talking to a behavioural flash;
// results are compared against a transaction-level round-robin/memory model.
module tb_spi_flash_arbiter;
   localparam int CS_GAP = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst_n;
   logic [1:0]        if_req, dr_req, if_ack, dr_ack;
   logic [1:0]        cs_n, sck, mosi, busy;
   logic [1:0]        miso = '0;
   logic [1:0][23:0]  if_addr, dr_addr;
   logic [1:0][31:0]  if_rdata, dr_rdata;

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_dut
      spi_flash_arbiter #(.CLK_DIV(gi == 0 ? 1 : 3), .CS_GAP(CS_GAP)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n[gi]),
         .if_req   (if_req[gi]),
         .if_addr  (if_addr[gi]),
         .if_ack   (if_ack[gi]),
         .if_rdata (if_rdata[gi]),
         .dr_req   (dr_req[gi]),
         .dr_addr  (dr_addr[gi]),
         .dr_ack   (dr_ack[gi]),
         .dr_rdata (dr_rdata[gi]),
         .spi_cs_n (cs_n[gi]),
         .spi_sck  (sck[gi]),
         .spi_mosi (mosi[gi]),
         .spi_miso (miso[gi]),
         .busy     (busy[gi])
      );
   end

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  mem [4096];
   logic [31:0] exp_if [2];
   logic [31:0] exp_dr [2];
   int          last_g [2];

   // flash model and bus monitors
   int          nbit [2];
   logic [31:0] cap [2];
   logic [31:0] cmdw [2];
   logic [23:0] faddr [2];
   int          run [2];
   int          phase_err [2];
   int          mosi_hi_chg [2];
   int          mosi_data_err [2];
   int          dual_cnt [2];
   logic        prev_sck [2];
   logic        prev_mosi [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int dv;
         int j;
         logic [7:0] b;
         dv = (k == 0) ? 1 : 3;
         if (if_ack[k] && dr_ack[k]) dual_cnt[k]++;
         if (prev_sck[k] && sck[k] && (mosi[k] !== prev_mosi[k])) mosi_hi_chg[k]++;
         if (sck[k] !== prev_sck[k]) begin
            if (run[k] != dv) phase_err[k]++;
            run[k] = 1;
         end else begin
            run[k]++;
         end
         if (cs_n[k]) begin
            nbit[k] = 0;
            run[k]  = 0;
         end else if (sck[k] && !prev_sck[k]) begin
            if (nbit[k] >= 32 && mosi[k]) mosi_data_err[k]++;
            cap[k] = {cap[k][30:0], mosi[k]};
            nbit[k]++;
            if (nbit[k] == 32) begin
               cmdw[k]  = cap[k];
               faddr[k] = cap[k][23:0];
            end
         end else if (!sck[k] && prev_sck[k] && nbit[k] >= 32 && nbit[k] < 64) begin
            j = nbit[k] - 32;
            b = mem[12'(faddr[k] + 24'(j / 8))];
            miso[k] = b[7 - (j % 8)];
         end
         prev_sck[k]  = sck[k];
         prev_mosi[k] = mosi[k];
      end
   end

   function automatic logic [31:0] exp_word(input logic [23:0] a);
      return {mem[12'(a + 24'd3)], mem[12'(a + 24'd2)], mem[12'(a + 24'd1)], mem[a[11:0]]};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(input int k);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy[k]) break;
      end
      check_val("idle", 64'(busy[k]), 64'(0));
   endtask

   // One request pattern from an idle DUT; optional requester drop at a given bit.
   task automatic run_one(input int k, input logic ri, input logic rd,
                          input logic [23:0] ai, input logic [23:0] ad, input int drop_bit);
      int d, exp_g, got_g, t0, tack, hold_bad, g;
      logic [23:0] ea;
      logic [31:0] ew;
      d = (k == 0) ? 1 : 3;
      if (ri && rd) exp_g = (last_g[k] == 1) ? 0 : 1;
      else exp_g = rd ? 1 : 0;
      last_g[k] = exp_g;
      ea = exp_g ? ad : ai;
      ew = exp_word(ea);
      if_addr[k] = ai;
      dr_addr[k] = ad;
      if_req[k]  = ri;
      dr_req[k]  = rd;
      t0 = cyc;
      hold_bad = 0;
      tack = -1;
      for (int c = 0; c < 200 * d + 50; c++) begin
         @(negedge clk);
         if (drop_bit >= 0 && nbit[k] >= drop_bit) begin
            if_req[k] = 1'b0;
            dr_req[k] = 1'b0;
         end
         if (if_ack[k] || dr_ack[k]) begin
            tack = cyc;
            break;
         end
         if (if_rdata[k] !== exp_if[k] || dr_rdata[k] !== exp_dr[k]) hold_bad++;
      end
      check_val("ack_seen", 64'(tack >= 0), 64'(1));
      got_g = dr_ack[k] ? 1 : 0;
      check_val("grant", 64'(got_g), 64'(exp_g));
      check_val("dual_ack", 64'(if_ack[k] & dr_ack[k]), 64'(0));
      check_val("latency", 64'(tack - t0), 64'(1 + 128 * d));
      if (exp_g == 0) exp_if[k] = ew;
      else exp_dr[k] = ew;
      check_val("if_rdata", 64'(if_rdata[k]), 64'(exp_if[k]));
      check_val("dr_rdata", 64'(dr_rdata[k]), 64'(exp_dr[k]));
      check_val("rdata_hold", 64'(hold_bad), 64'(0));
      check_val("mosi_word", 64'(cmdw[k]), 64'({8'h03, ea}));
      $display("txn dut%0d gnt=%s addr=%06h data=%08h ack_cycle=%0d", k,
               exp_g ? "dr" : "if", ea, exp_g ? dr_rdata[k] : if_rdata[k], tack);
      if_req[k] = 1'b0;
      dr_req[k] = 1'b0;
      g = 0;
      for (int c = 0; c < CS_GAP + 4; c++) begin
         @(negedge clk);
         if (busy[k] && cs_n[k]) g++;
         else break;
      end
      check_val("gap_len", 64'(g), 64'(CS_GAP));
      check_val("idle_cs", 64'({busy[k], cs_n[k]}), 64'(2'b01));
   endtask

   // Both requests held from the first cycle after reset over four grants.
   task automatic hold_both(input int k);
      int t0, tprev, tack, exp_g, got_g;
      logic [23:0] ai, ad;
      ai = 24'($urandom);
      ad = 24'($urandom);
      if_addr[k] = ai;
      dr_addr[k] = ad;
      if_req[k]  = 1'b1;
      dr_req[k]  = 1'b1;
      rst_n[k]   = 1'b1;
      t0 = cyc;
      tprev = t0;
      for (int n = 0; n < 4; n++) begin
         tack = -1;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (if_ack[k] || dr_ack[k]) begin
               tack = cyc;
               break;
            end
         end
         exp_g = (last_g[k] == 1) ? 0 : 1;
         last_g[k] = exp_g;
         got_g = dr_ack[k] ? 1 : 0;
         check_val("rr_grant", 64'(got_g), 64'(exp_g));
         if (n == 0) check_val("rr_first", 64'(tack - t0), 64'(129));
         else check_val("rr_space", 64'(tack - tprev), 64'(2 + 128 + CS_GAP));
         if (exp_g == 0) exp_if[k] = exp_word(ai);
         else exp_dr[k] = exp_word(ad);
         check_val("rr_data", 64'({if_rdata[k], dr_rdata[k]}), 64'({exp_if[k], exp_dr[k]}));
         $display("txn dut%0d rr gnt=%s ack_cycle=%0d", k, exp_g ? "dr" : "if", tack);
         tprev = tack;
      end
      if_req[k] = 1'b0;
      dr_req[k] = 1'b0;
      wait_idle(k);
   endtask

   initial begin
      logic [1:0] r;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[256] = 8'h13; mem[257] = 8'h05; mem[258] = 8'h00; mem[259] = 8'h00;
      mem[512] = 8'hEF; mem[513] = 8'hBE; mem[514] = 8'hAD; mem[515] = 8'hDE;
      for (int k = 0; k < 2; k++) begin
         exp_if[k] = '0; exp_dr[k] = '0; last_g[k] = 1;
         nbit[k] = 0; cap[k] = '0; cmdw[k] = '0; faddr[k] = '0; run[k] = 0;
         phase_err[k] = 0; mosi_hi_chg[k] = 0; mosi_data_err[k] = 0; dual_cnt[k] = 0;
         prev_sck[k] = 1'b0; prev_mosi[k] = 1'b0;
      end
      rst_n = '0; if_req = '0; dr_req = '0; if_addr = '0; dr_addr = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_val("reset_pins", 64'({cs_n[k], sck[k], mosi[k], if_ack[k], dr_ack[k], busy[k]}),
                   64'(6'b100000));
         check_val("reset_rdata", {if_rdata[k], dr_rdata[k]}, 64'h0);
      end
      rst_n[1] = 1'b1;
      hold_both(0);

      run_one(0, 1'b1, 1'b0, 24'h000100, 24'($urandom), -1);
      check_val("plan_word", 64'(if_rdata[0]), 64'h00000513);
      run_one(0, 1'b0, 1'b1, 24'($urandom), 24'h000200, -1);
      check_val("deadbeef", 64'(dr_rdata[0]), 64'hDEADBEEF);
      run_one(0, 1'b0, 1'b1, 24'($urandom), 24'h000204, -1);
      run_one(0, 1'b0, 1'b1, 24'($urandom), 24'($urandom), 40);
      for (int i = 0; i < 10; i++) begin
         r = 2'($urandom_range(1, 3));
         run_one(0, r[0], r[1], 24'($urandom), 24'($urandom), -1);
      end

      // asynchronous reset in the middle of a frame
      if_addr[0] = 24'($urandom);
      if_req[0]  = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (nbit[0] >= 20) break;
      end
      check_val("mid_busy", 64'(busy[0]), 64'(1));
      #2 rst_n[0] = 1'b0;
      #1;
      check_val("rst_async", 64'({cs_n[0], sck[0], mosi[0], if_ack[0], dr_ack[0], busy[0]}),
                64'(6'b100000));
      check_val("rst_rdata", {if_rdata[0], dr_rdata[0]}, 64'h0);
      if_req[0] = 1'b0;
      exp_if[0] = '0; exp_dr[0] = '0; last_g[0] = 1;
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      run_one(0, 1'b1, 1'b1, 24'($urandom), 24'($urandom), -1);

      for (int i = 0; i < 4; i++) begin
         r = 2'($urandom_range(1, 3));
         run_one(1, r[0], r[1], 24'($urandom), 24'($urandom), -1);
      end
      check_val("sck_phase_div3", 64'(phase_err[1]), 64'(0));
      check_val("mosi_stable_hi", 64'(mosi_hi_chg[1]), 64'(0));
      check_val("mosi_data0_d1", 64'(mosi_data_err[0]), 64'(0));
      check_val("mosi_data0_d3", 64'(mosi_data_err[1]), 64'(0));
      check_val("dual_ack_mon", 64'(dual_cnt[0] + dual_cnt[1]), 64'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
